// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared state codes, lamp encodings and lamp decode for the junction controller
package tlc_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5
    } state_t;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Returns {main_light, side_light}; any unknown code decodes to both red.
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            MAIN_GREEN:  lamps = {LT_GRN, LT_RED};
            MAIN_YELLOW: lamps = {LT_YEL, LT_RED};
            SIDE_GREEN:  lamps = {LT_RED, LT_GRN};
            SIDE_YELLOW: lamps = {LT_RED, LT_YEL};
            default:     lamps = {LT_RED, LT_RED};
        endcase
    endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// rtl/tlc_dwell_timer.sv - per-state dwell counter, cleared on state entry, saturating
module tlc_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tlc_junction_ctrl.sv
// rtl/tlc_junction_ctrl.sv - two-road junction FSM with internal dwell timer
// Optional pedestrian request (ped_req/walk) enabled by macro TLC_PED_REQ_EN.
module tlc_junction_ctrl
    import tlc_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int MAIN_MIN = 20,
    parameter int SIDE_MIN = 5,
    parameter int SIDE_MAX = 15,
    parameter int YEL_T    = 3,
    parameter int RED_T    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car,
`ifdef TLC_PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] state_o,
    output logic       tmr_start
);

    localparam logic [CNT_W-1:0] MAIN_LIM = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SMIN_LIM = CNT_W'(SIDE_MIN - 1);
    localparam logic [CNT_W-1:0] SMAX_LIM = CNT_W'(SIDE_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LIM  = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] RED_LIM  = CNT_W'(RED_T - 1);

    state_t           state;
    state_t           next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       main_q;
    logic [2:0]       side_q;
    logic             changing;
    logic             demand;
    logic             side_done;

`ifdef TLC_PED_REQ_EN
    logic ped_latch;
    logic ped_hold;

    assign demand    = car || ped_latch || ped_req;
    assign side_done = ped_hold ? (cnt >= SMIN_LIM) : (!car && cnt >= SMIN_LIM);
    assign walk      = (state == SIDE_GREEN);

    // ped_hold remembers whether this side-green phase was granted to a pedestrian.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ped_latch <= 1'b0;
            ped_hold  <= 1'b0;
        end else if (changing && next == SIDE_GREEN) begin
            ped_latch <= 1'b0;
            ped_hold  <= ped_latch;
        end else if (ped_req) begin
            ped_latch <= 1'b1;
        end
    end
`else
    assign demand    = car;
    assign side_done = !car && cnt >= SMIN_LIM;
`endif

    always_comb begin
        next = state;
        case (state)
            MAIN_GREEN:  if (demand && cnt >= MAIN_LIM)           next = MAIN_YELLOW;
            MAIN_YELLOW: if (cnt == YEL_LIM)                      next = ALL_RED_1;
            ALL_RED_1:   if (cnt == RED_LIM)                      next = SIDE_GREEN;
            SIDE_GREEN:  if (side_done || cnt == SMAX_LIM)        next = SIDE_YELLOW;
            SIDE_YELLOW: if (cnt == YEL_LIM)                      next = ALL_RED_2;
            ALL_RED_2:   if (cnt == RED_LIM)                      next = MAIN_GREEN;
            default:                                              next = MAIN_GREEN;
        endcase
    end

    assign changing = (next != state);

    tlc_dwell_timer #(.CNT_W(CNT_W)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (changing),
        .cnt (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= MAIN_GREEN;
            main_q    <= LT_GRN;
            side_q    <= LT_RED;
            tmr_start <= 1'b0;
        end else begin
            state            <= next;
            {main_q, side_q} <= lamps(next);
            tmr_start        <= changing;
        end
    end

    // A corrupted state code forces both roads red until the FSM recovers.
    assign main_light = (state > ALL_RED_2) ? LT_RED : main_q;
    assign side_light = (state > ALL_RED_2) ? LT_RED : side_q;
    assign state_o    = state;

endmodule

// File: tb/tb_tlc_junction_ctrl.sv
// tb/tb_tlc_junction_ctrl.sv - directed self-checking bench for tlc_junction_ctrl
module tb_tlc_junction_ctrl;

    logic       clk;
    logic       rst;
    logic       car;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [2:0] state_o;
    logic       tmr_start;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_main [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] exp_side [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int         dwell    [6] = '{20, 3, 2, 15, 3, 2};

    tlc_junction_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .car        (car),
        .main_light (main_light),
        .side_light (side_light),
        .state_o    (state_o),
        .tmr_start  (tmr_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic car_val);
        rst = 1'b1;
        car = car_val;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        car = 1'b1;
        tick();
        checks++;
        if ({state_o, main_light, side_light, tmr_start} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got st=%0d m=%b s=%b ts=%b want st=0 m=001 s=100 ts=0",
                     state_o, main_light, side_light, tmr_start);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_saturation();
        int pulses = 0;
        int bad = 0;
        do_reset(1'b0);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (tmr_start) pulses++;
            if (state_o !== 3'd0 || main_light !== 3'b001 || side_light !== 3'b100) bad++;
            if (k == 99) begin
                checks++;
                if (bad != 0 || pulses != 0) begin
                    errors++;
                    $display("FAIL idle_100 got bad=%0d pulses=%0d want 0 0", bad, pulses);
                end
            end
        end
        checks++;
        if (bad != 0 || pulses != 0) begin
            errors++;
            $display("FAIL idle_300 got bad=%0d pulses=%0d want 0 0", bad, pulses);
        end
        checks++;
        if (u_dut.cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_saturate got %0d want 255", u_dut.cnt);
        end
        car = 1'b1;
        tick();
        checks++;
        if (state_o !== 3'd1 || tmr_start !== 1'b1 || main_light !== 3'b010) begin
            errors++;
            $display("FAIL sat_to_yellow got st=%0d ts=%b m=%b want st=1 ts=1 m=010",
                     state_o, tmr_start, main_light);
        end
    endtask

    task automatic test_full_cycle();
        int pulses = 0;
        int st = 0;
        int left;
        do_reset(1'b1);
        left = dwell[0];
        for (int k = 1; k <= 45; k++) begin
            tick();
            left--;
            if (left == 0) begin
                st = (st + 1) % 6;
                left = dwell[st];
            end
            if (tmr_start) pulses++;
            checks++;
            if (state_o !== 3'(st) || main_light !== exp_main[st] || side_light !== exp_side[st]) begin
                errors++;
                $display("FAIL cycle_k%0d got st=%0d m=%b s=%b want st=%0d m=%b s=%b",
                         k, state_o, main_light, side_light, st, exp_main[st], exp_side[st]);
            end
            checks++;
            if (main_light != 3'b100 && side_light != 3'b100) begin
                errors++;
                $display("FAIL safety_k%0d got m=%b s=%b want one road red", k, main_light, side_light);
            end
        end
        checks++;
        if (pulses != 6 || tmr_start !== 1'b1) begin
            errors++;
            $display("FAIL pulse_count got %0d ts=%b want 6 ts=1", pulses, tmr_start);
        end
    endtask

    task automatic test_side_early(input int drop_cnt, input int want_len);
        int len = 0;
        int guard = 0;
        do_reset(1'b1);
        while (state_o !== 3'd3 && guard < 100) begin
            tick();
            guard++;
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL side_reach got st=%0d want 3", state_o);
        end
        while (state_o === 3'd3 && len < 30) begin
            if (len == drop_cnt) car = 1'b0;
            len++;
            tick();
        end
        checks++;
        if (len != want_len || state_o !== 3'd4) begin
            errors++;
            $display("FAIL side_drop_%0d got len=%0d st=%0d want len=%0d st=4",
                     drop_cnt, len, state_o, want_len);
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        do_reset(1'b1);
        while (state_o !== 3'd4 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({state_o, main_light, side_light, tmr_start} !== {3'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got st=%0d m=%b s=%b ts=%b want st=0 m=001 s=100 ts=0",
                     state_o, main_light, side_light, tmr_start);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (u_dut.cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_release got %0d want 0", u_dut.cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        car = 1'b0;
        test_reset();
        test_idle_saturation();
        test_full_cycle();
        test_side_early(2, 5);
        test_side_early(8, 9);
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
